// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared widths, frame constants and state encoding for lbp_hist
package lbp_pkg;
    localparam int CODE_W    = 8;
    localparam int BIN_W     = 14;
    localparam int NBINS     = 1 << CODE_W;
    localparam int IMG_W     = 128;
    localparam int IMG_H     = 128;
    localparam int MAX_CODES = (IMG_W - 2) * (IMG_H - 2);

    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/lbp_hist_if.sv
// rtl/lbp_hist_if.sv - code input, control and histogram output bundle
interface lbp_hist_if;
    import lbp_pkg::*;

    logic              lbp_valid;
    logic [CODE_W-1:0] lbp_data;
    logic              lbp_finish;
    logic              start;
    logic              hist_valid;
    logic              hist_ready;
    logic [CODE_W-1:0] hist_bin;
    logic [BIN_W-1:0]  hist_data;
    logic              hist_done;
    logic              drop_err;

    modport master (
        output lbp_valid, lbp_data, lbp_finish, start, hist_ready,
        input  hist_valid, hist_bin, hist_data, hist_done, drop_err
    );

    modport slave (
        input  lbp_valid, lbp_data, lbp_finish, start, hist_ready,
        output hist_valid, hist_bin, hist_data, hist_done, drop_err
    );
endinterface

// File: rtl/hist_ram.sv
// rtl/hist_ram.sv - bin storage, one write and one synchronous read port, old data on collision
module hist_ram #(
    parameter int AW = 8,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - LBP code histogram: 2-stage accumulate, drain, stream 256 bins out
module lbp_hist
    import lbp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    lbp_hist_if.slave bus
);
    state_t            r_state, w_state_nxt;
    logic              r_fin_d, r_drain_cnt, r_drop_err;
    logic [NBINS-1:0]  r_vbit;
    logic              r_s1_vld, r_fw_vld;
    logic [CODE_W-1:0] r_s1_bin, r_fw_bin;
    logic [BIN_W-1:0]  r_fw_val;
    logic [CODE_W:0]   r_rd_cnt;
    logic              r_rd_pend, r_pf_vld, r_out_vld;
    logic [CODE_W-1:0] r_rd_bin, r_pf_bin, r_out_bin;
    logic [BIN_W-1:0]  r_pf_data, r_out_data;
    logic [BIN_W-1:0]  w_rdata, w_old, w_new, w_ret_data;
    logic [CODE_W-1:0] w_raddr;
    logic              w_in_accum, w_in_drain, w_in_out, w_in_done;
    logic              w_s0_vld, w_fin_rise, w_accept, w_out_free, w_issue, w_clear;

    hist_ram #(.AW(CODE_W), .DW(BIN_W)) u_ram (
        .clk     (clk),
        .i_we    (r_s1_vld),
        .i_waddr (r_s1_bin),
        .i_wdata (w_new),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_fin_rise) w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_cnt) w_state_nxt = OUT;
            OUT:     if (w_accept && r_out_bin == '1) w_state_nxt = DONE;
            DONE:    if (bus.start) w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        w_in_accum    = (r_state == ACCUM);
        w_in_drain    = (r_state == DRAIN);
        w_in_out      = (r_state == OUT);
        w_in_done     = (r_state == DONE);
        bus.hist_done = w_in_done;
    end

    assign w_fin_rise = bus.lbp_finish & ~r_fin_d;
    assign w_s0_vld   = bus.lbp_valid & w_in_accum;
    assign w_clear    = w_in_done & bus.start;
    assign w_raddr    = w_in_out ? r_rd_cnt[CODE_W-1:0] : bus.lbp_data;

    // Back-to-back hits on one bin read stale RAM data, so take the value written last cycle.
    assign w_old = (r_fw_vld && r_fw_bin == r_s1_bin) ? r_fw_val
                 : (r_vbit[r_s1_bin] ? w_rdata : '0);
    assign w_new = (w_old == BIN_MAX) ? w_old : w_old + BIN_W'(1);

    assign w_ret_data = r_vbit[r_rd_bin] ? w_rdata : '0;
    assign w_accept   = r_out_vld & bus.hist_ready;
    assign w_out_free = ~r_out_vld | w_accept;
    // Only issue a read if its data is guaranteed a slot (output or prefetch) on return.
    assign w_issue    = w_in_out & ~r_rd_cnt[CODE_W] & ~r_pf_vld & ~(r_rd_pend & ~w_out_free);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fin_d     <= 1'b0;
            r_drain_cnt <= 1'b0;
            r_drop_err  <= 1'b0;
            r_vbit      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_bin    <= '0;
            r_fw_vld    <= 1'b0;
            r_fw_bin    <= '0;
            r_fw_val    <= '0;
        end else begin
            r_fin_d     <= bus.lbp_finish;
            r_drain_cnt <= w_in_drain ? ~r_drain_cnt : 1'b0;
            r_s1_vld    <= w_s0_vld;
            r_s1_bin    <= bus.lbp_data;
            r_fw_vld    <= r_s1_vld;
            if (r_s1_vld) begin
                r_fw_bin <= r_s1_bin;
                r_fw_val <= w_new;
            end
            if (w_clear)               r_vbit           <= '0;
            else if (r_s1_vld)         r_vbit[r_s1_bin] <= 1'b1;
            if (w_clear)               r_drop_err <= 1'b0;
            else if (bus.lbp_valid && !w_in_accum) r_drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_cnt   <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_bin   <= '0;
            r_pf_vld   <= 1'b0;
            r_pf_bin   <= '0;
            r_pf_data  <= '0;
            r_out_vld  <= 1'b0;
            r_out_bin  <= '0;
            r_out_data <= '0;
        end else if (!w_in_out) begin
            r_rd_cnt  <= '0;
            r_rd_pend <= 1'b0;
            r_pf_vld  <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            r_rd_cnt  <= r_rd_cnt + {{CODE_W{1'b0}}, w_issue};
            if (w_issue) r_rd_bin <= r_rd_cnt[CODE_W-1:0];
            if (w_out_free) begin
                if (r_pf_vld) begin
                    r_out_vld  <= 1'b1;
                    r_out_bin  <= r_pf_bin;
                    r_out_data <= r_pf_data;
                    r_pf_vld   <= r_rd_pend;
                    r_pf_bin   <= r_rd_bin;
                    r_pf_data  <= w_ret_data;
                end else begin
                    r_out_vld  <= r_rd_pend;
                    r_out_bin  <= r_rd_bin;
                    r_out_data <= w_ret_data;
                end
            end else if (r_rd_pend) begin
                r_pf_vld  <= 1'b1;
                r_pf_bin  <= r_rd_bin;
                r_pf_data <= w_ret_data;
            end
        end
    end

    assign bus.hist_valid = r_out_vld;
    assign bus.hist_bin   = r_out_bin;
    assign bus.hist_data  = r_out_data;
    assign bus.drop_err   = r_drop_err;
endmodule

// File: tb/tb_lbp_hist.sv
// tb/tb_lbp_hist.sv - randomized self-checking bench for lbp_hist against a counting model
module tb_lbp_hist;
    import lbp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    lbp_hist_if bus ();

    lbp_hist dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    int  model [NBINS];
    bit  accum;
    localparam int SAT = (1 << BIN_W) - 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NBINS; i++) model[i] = 0;
        accum = 1'b1;
    endtask

    task automatic send(input int c, input int gap);
        bus.lbp_valid = 1'b1;
        bus.lbp_data  = CODE_W'(c);
        tick();
        bus.lbp_valid = 1'b0;
        if (accum && model[c] < SAT) model[c]++;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic finish(input bit with_code, input int c);
        bus.lbp_finish = 1'b1;
        bus.lbp_valid  = with_code;
        bus.lbp_data   = CODE_W'(c);
        tick();
        if (with_code && model[c] < SAT) model[c]++;
        accum          = 1'b0;
        bus.lbp_finish = 1'b0;
        bus.lbp_valid  = 1'b0;
    endtask

    task automatic read_hist(input int ready_pct, input int inject_at);
        int hs = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        int sb = 0;
        int sd = 0;
        while (hs < NBINS && cyc < 4000) begin
            bus.hist_ready = ($urandom_range(0, 99) < ready_pct);
            bus.lbp_valid  = (hs == inject_at);
            bus.lbp_data   = CODE_W'($urandom);
            if (stalled) begin
                chk("stall_valid", bus.hist_valid, 1);
                chk("stall_bin", bus.hist_bin, sb);
                chk("stall_data", bus.hist_data, sd);
            end
            if (bus.hist_valid && bus.hist_ready) begin
                chk("bin_order", bus.hist_bin, hs);
                chk("bin_data", bus.hist_data, model[hs]);
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = bus.hist_valid;
                sb      = bus.hist_bin;
                sd      = bus.hist_data;
            end
            tick();
            cyc++;
        end
        bus.lbp_valid  = 1'b0;
        bus.hist_ready = 1'b0;
        chk("handshakes", hs, NBINS);
        chk("done_after_last", bus.hist_done, 1);
        chk("valid_drop_last", bus.hist_valid, 0);
    endtask

    task automatic rearm();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        clear_model();
        chk("done_clr_on_start", bus.hist_done, 0);
        chk("drop_clr_on_start", bus.drop_err, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        clear_model();
        chk("rst_hist_valid", bus.hist_valid, 0);
        chk("rst_hist_done", bus.hist_done, 0);
        chk("rst_drop_err", bus.drop_err, 0);
    endtask

    initial begin
        bus.lbp_valid  = 1'b0;
        bus.lbp_data   = '0;
        bus.lbp_finish = 1'b0;
        bus.start      = 1'b0;
        bus.hist_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 4; i++) send(5, 0);
        finish(1'b0, 0);
        read_hist(100, -1);
        chk("drop_same_bin", bus.drop_err, 0);
        rearm();

        send(7, 0); send(9, 0); send(7, 0); send(9, 1); send(7, 0);
        finish(1'b0, 0);
        read_hist(100, -1);
        rearm();

        for (int i = 0; i < 400; i++) send($urandom_range(0, 15), $urandom_range(0, 2));
        finish(1'b1, 3);
        send(4, 0);
        chk("drop_in_drain", bus.drop_err, 1);
        read_hist(50, 100);
        chk("drop_in_out", bus.drop_err, 1);
        rearm();

        for (int i = 0; i < 10; i++) send(200, 0);
        finish(1'b0, 0);
        read_hist(60, -1);
        rearm();

        for (int i = 0; i < MAX_CODES; i++) send(i % NBINS, $urandom_range(0, 1));
        finish(1'b0, 0);
        read_hist(70, -1);
        rearm();

        for (int i = 0; i < SAT + 20; i++) send(33, 0);
        send(34, 0);
        finish(1'b0, 0);
        read_hist(80, -1);
        rearm();

        for (int i = 0; i < 50; i++) send($urandom_range(0, 255), $urandom_range(0, 1));
        finish(1'b0, 0);
        bus.hist_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b0;
        #1;
        chk("midout_hist_valid", bus.hist_valid, 0);
        chk("midout_hist_done", bus.hist_done, 0);
        tick();
        reset = 1'b1;
        bus.hist_ready = 1'b0;
        clear_model();
        tick();
        for (int i = 0; i < 120; i++) send($urandom_range(0, 7), $urandom_range(0, 1));
        chk("post_reset_no_drop", bus.drop_err, 0);
        finish(1'b0, 0);
        read_hist(50, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lbp_hist.md
Name: lbp_hist

Overview:
- Downstream consumer of the LBP engine's output stream (lbp_valid/lbp_data, one code per interior pixel of the 128x128 frame).
- Accumulates a 256-bin histogram of LBP codes in an internal synchronous-read RAM.
- On the engine's finish, streams all 256 bins out over a valid/ready port for the feature/classifier stage.
- Re-arms for the next frame on a start pulse, without a multi-cycle clear sweep.

Parameters:
- CODE_W, 8, LBP code width; bin count = 2**CODE_W.
- BIN_W, 14, bin counter width; a full frame has 126*126 = 15876 codes max, which fits.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous, active-low reset.
- lbp_valid, input, 1, code valid this cycle; there is no backpressure, so every valid code must be accepted.
- lbp_data, input, CODE_W, LBP code.
- lbp_finish, input, 1, engine finish; level or pulse, rising edge is used.
- start, input, 1, single-cycle re-arm pulse, honoured only in DONE.
- hist_valid, output, 1, bin output valid.
- hist_ready, input, 1, downstream accept.
- hist_bin, output, CODE_W, bin index of hist_data.
- hist_data, output, BIN_W, bin count.
- hist_done, output, 1, high in DONE.
- drop_err, output, 1, sticky; a code arrived while not in ACCUM.

Behaviour:
- Reset (reset=0): state=ACCUM, all bin-valid bits=0, pipeline empty, all outputs 0.
- Clearing:
  - A 2**CODE_W-bit vbit register marks which bins hold data.
  - A RAM read of a bin with vbit=0 is treated as 0.
  - Clearing the histogram is one cycle: vbit<=0.
- ACCUM pipeline, 2 stages, initiation interval 1:
  - S0, the cycle lbp_valid=1: issue RAM read at lbp_data; register bin and valid into S1.
  - S1, next cycle:
    - old = fw_hit ? fw_val : (vbit[bin] ? rdata : 0).
    - new = old+1, saturating at 2**BIN_W-1.
    - Write RAM[bin]=new; set vbit[bin]=1; load fw_bin=bin, fw_val=new, fw_vld=1.
  - fw_hit = fw_vld & fw_bin==S1 bin & the forward register was loaded in the immediately preceding cycle. This covers back-to-back codes to the same bin.
  - RAM read-during-write to the same address returns OLD data; the forwarding above compensates.
  - Latency from input code to bin updated in RAM: 2 cycles.
- State machine: ACCUM -> DRAIN -> OUT -> DONE -> ACCUM.
  - ACCUM -> DRAIN on rising edge of lbp_finish. A code valid in that same cycle is still counted.
  - DRAIN (2 cycles): pipeline empties. lbp_valid here sets drop_err and is not counted.
  - OUT:
    - Sequencer reads bins 0..2**CODE_W-1 in order. Data arrives the cycle after the read is issued.
    - hist_valid rises with bin 0 data.
    - hist_bin/hist_data hold stable while hist_valid & !hist_ready.
    - Advance on hist_valid & hist_ready.
    - Throughput 1 bin/cycle when hist_ready is held high; 1-entry prefetch register allowed.
    - Unwritten bins output 0.
  - OUT -> DONE after bin 255 handshakes; hist_valid drops the same edge.
  - DONE: hist_done=1.
    - start=1 -> vbit<=0, drop_err<=0, state ACCUM next cycle.
    - start outside DONE is ignored.
- lbp_valid in OUT/DONE sets drop_err; the histogram is unchanged.
- Reset asserted mid-operation: immediate return to reset values; the RAM contents need not be cleared because vbit=0 masks them.

Decomposition:
- Shared package lbp_pkg holds:
  - CODE_W and BIN_W.
  - Frame constants: IMG_W=128, IMG_H=128, MAX_CODES=15876.
  - State enum ACCUM/DRAIN/OUT/DONE.
- One sub-module, hist_ram:
  - Single-port-write / single-port-read, 2**CODE_W x BIN_W, synchronous read.
  - Read-during-write returns old data.
  - No reset on storage.

Test Plan:
- Codes 5,5,5,5 on 4 consecutive cycles, then finish -> bin 5 reads 4; all other bins read 0; drop_err=0.
- Alternating codes 7,9,7,9 back-to-back, then 7 after a 1-cycle gap -> bin 7=3, bin 9=2. This exercises both the forward and the non-forward paths.
- Full frame, 15876 codes with code=index mod 256, lbp_valid every 13 cycles:
  - Bins 0..3 read 63; bins 4..255 read 62.
  - 256 handshakes, then hist_done=1.
- Output with hist_ready toggling pseudo-randomly:
  - hist_bin is strictly 0..255, with no skip and no duplicate.
  - Data is stable while stalled.
- Frame 2 after start, codes all =200 x10 -> bin 200=10; frame-1 bins read 0, proving the single-cycle clear.
- lbp_valid during OUT -> drop_err=1 and the histogram is unchanged. Assert reset mid-OUT -> hist_valid=0 and state ACCUM, and a following frame counts correctly.
